// File: rtl/input_debouncer.sv
// input_debouncer: two-flop synchroniser followed by a four-state qualification
// FSM. The output follows the synchronised input only after the new level has
// been seen on STABLE_CNT+1 consecutive cycles: the entry cycle plus STABLE_CNT
// counted cycles. A check that is abandoned before completion raises a
// one-cycle bounce pulse.
module input_debouncer #(
  parameter int STABLE_CNT = 1000,
  parameter int CNT_W      = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic busy,
  output logic bounce
);

  // Elaboration-time guard: the counter must be able to reach STABLE_CNT-1.
  generate
    if (STABLE_CNT < 1 || (64'd1 << CNT_W) < 64'(STABLE_CNT)) begin : g_bad_param
      $error("input_debouncer: STABLE_CNT must be in 1 .. 2**CNT_W");
    end
  endgenerate

  typedef enum logic [1:0] {
    LO     = 2'd0,
    CHK_HI = 2'd1,
    HI     = 2'd2,
    CHK_LO = 2'd3
  } state_t;

  // Last count value before a qualification completes.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

  logic             s0_reg;
  logic             s1_reg;
  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             out_reg;
  logic             out_next;
  logic             bounce_reg;
  logic             bounce_next;

  // State register, synchroniser and registered outputs.
  // Reset discards any check in progress without producing a bounce pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_reg     <= 1'b0;
      s1_reg     <= 1'b0;
      state_reg  <= LO;
      cnt_reg    <= '0;
      out_reg    <= 1'b0;
      bounce_reg <= 1'b0;
    end else begin
      s0_reg     <= in;
      s1_reg     <= s0_reg;
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      out_reg    <= out_next;
      bounce_reg <= bounce_next;
    end
  end

  // Next-state logic. An abort is checked before completion, so a level that
  // drops back on the final counted cycle is still rejected.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    out_next    = out_reg;
    bounce_next = 1'b0;
    unique case (state_reg)
      LO: begin
        if (s1_reg) begin
          state_next = CHK_HI;
          cnt_next   = '0;
        end
      end
      CHK_HI: begin
        if (!s1_reg) begin
          state_next  = LO;
          bounce_next = 1'b1;
          cnt_next    = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = HI;
          out_next   = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      HI: begin
        if (!s1_reg) begin
          state_next = CHK_LO;
          cnt_next   = '0;
        end
      end
      CHK_LO: begin
        if (s1_reg) begin
          state_next  = HI;
          bounce_next = 1'b1;
          cnt_next    = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = LO;
          out_next   = 1'b0;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next = LO;
        cnt_next   = '0;
      end
    endcase
  end

  // Output decode: busy comes straight from the registered state, so it is
  // glitch-free; out and bounce are registered.
  always_comb begin
    busy   = (state_reg == CHK_HI) || (state_reg == CHK_LO);
    out    = out_reg;
    bounce = bounce_reg;
  end

endmodule

// File: tb/tb_input_debouncer.sv
// tb_input_debouncer: three debouncer instances (STABLE_CNT = 4, 1 and 8)
// share one clock and reset. Each instance is paired with a run-length
// reference model: the FSM sees the input two cycles late, and out flips once
// the sampled level has differed from out on STABLE_CNT+1 consecutive samples.
// A differing run that ends early counts as one bounce.
module tb_input_debouncer;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] in_v;
  logic [2:0] out_v;
  logic [2:0] busy_v;
  logic [2:0] bounce_v;

  input_debouncer #(.STABLE_CNT(4), .CNT_W(3)) u_p4 (
    .clk(clk), .rst(rst), .in(in_v[0]), .out(out_v[0]), .busy(busy_v[0]), .bounce(bounce_v[0]));
  input_debouncer #(.STABLE_CNT(1), .CNT_W(1)) u_p1 (
    .clk(clk), .rst(rst), .in(in_v[1]), .out(out_v[1]), .busy(busy_v[1]), .bounce(bounce_v[1]));
  input_debouncer #(.STABLE_CNT(8), .CNT_W(4)) u_p8 (
    .clk(clk), .rst(rst), .in(in_v[2]), .out(out_v[2]), .busy(busy_v[2]), .bounce(bounce_v[2]));

  always #5 clk = ~clk;

  int   p_cnt [3] = '{4, 1, 8};
  logic h1 [3];
  logic h2 [3];
  int   run [3];
  logic m_out [3];
  logic m_bounce [3];
  int   aborts [3];
  int   dut_bounces [3];

  int n_checks = 0;
  int n_fail   = 0;

  // Single comparison point for the whole bench.
  task automatic check(input string tag, input int d, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d (STABLE_CNT=%0d) at %0t: got %0d, expected %0d",
               tag, d, p_cnt[d], $time, got, exp);
    end
  endtask

  // Reference model update for one rising edge, using the inputs applied
  // before that edge.
  task automatic model_step(input logic r);
    logic smp;
    for (int d = 0; d < 3; d++) begin
      if (r) begin
        h1[d] = 1'b0; h2[d] = 1'b0; run[d] = 0; m_out[d] = 1'b0; m_bounce[d] = 1'b0;
      end else begin
        smp         = h2[d];
        h2[d]       = h1[d];
        h1[d]       = in_v[d];
        m_bounce[d] = 1'b0;
        if (smp != m_out[d]) begin
          run[d]++;
          if (run[d] == p_cnt[d] + 1) begin
            m_out[d] = smp;
            run[d]   = 0;
          end
        end else if (run[d] > 0) begin
          run[d]      = 0;
          m_bounce[d] = 1'b1;
          aborts[d]++;
        end
      end
    end
  endtask

  // One clock cycle: apply inputs, clock the model, compare at the falling edge.
  task automatic cyc(input logic r, input logic [2:0] v);
    rst  = r;
    in_v = v;
    @(posedge clk);
    model_step(r);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("model_out", d, out_v[d], m_out[d]);
      check("model_busy", d, busy_v[d], run[d] > 0);
      check("model_bounce", d, bounce_v[d], m_bounce[d]);
      if (bounce_v[d] === 1'b1) dut_bounces[d]++;
    end
  endtask

  // Drive a two-cycle reset on every instance.
  task automatic do_reset();
    cyc(1'b1, 3'b000);
    cyc(1'b1, 3'b000);
  endtask

  int   phase_bnc;
  int   toggles;
  logic prev_out;
  int   hold [3];
  logic [2:0] v;

  initial begin
    rst  = 1'b1;
    in_v = 3'b000;
    for (int d = 0; d < 3; d++) begin
      h1[d] = 1'b0; h2[d] = 1'b0; run[d] = 0; m_out[d] = 1'b0; m_bounce[d] = 1'b0;
      aborts[d] = 0; dut_bounces[d] = 0; hold[d] = 1;
    end
    @(negedge clk);

    // Reset state.
    do_reset();
    for (int d = 0; d < 3; d++) begin
      check("rst_out", d, out_v[d], 0);
      check("rst_busy", d, busy_v[d], 0);
      check("rst_bounce", d, bounce_v[d], 0);
    end

    // Clean rise: busy over edges 3..6 and out at edge 7 for STABLE_CNT=4;
    // out at edge 4 for STABLE_CNT=1.
    for (int e = 1; e <= 8; e++) begin
      cyc(1'b0, 3'b111);
      check("rise_busy", 0, busy_v[0], (e >= 3 && e <= 6));
      check("rise_out", 0, out_v[0], (e >= 7));
      check("rise_bounce", 0, bounce_v[0], 0);
      check("rise_out", 1, out_v[1], (e >= 4));
    end

    // Fall path at STABLE_CNT=1: out drops at edge 4.
    for (int e = 1; e <= 5; e++) begin
      cyc(1'b0, 3'b000);
      check("fall_out", 1, out_v[1], (e < 4));
    end

    // Bounce reject: high 2, low 3, then high held; out rises at edge 12.
    do_reset();
    phase_bnc = 0;
    for (int e = 1; e <= 13; e++) begin
      cyc(1'b0, (e <= 2 || e >= 6) ? 3'b111 : 3'b000);
      if (bounce_v[0] === 1'b1) phase_bnc++;
      check("reject_out", 0, out_v[0], (e >= 12));
    end
    check("reject_bounces", 0, phase_bnc, 1);

    // Late abort: the level drops back on the cycle where cnt == 3.
    do_reset();
    for (int e = 1; e <= 9; e++) begin
      cyc(1'b0, (e <= 4) ? 3'b111 : 3'b000);
      check("late_bounce", 0, bounce_v[0], (e == 7));
      check("late_busy", 0, busy_v[0], (e >= 3 && e <= 6));
      check("late_out", 0, out_v[0], 0);
    end

    // Reset mid-check at STABLE_CNT=8 (cnt == 5 after edge 8).
    do_reset();
    for (int e = 1; e <= 8; e++) cyc(1'b0, 3'b111);
    check("midrst_busy_before", 2, busy_v[2], 1);
    cyc(1'b1, 3'b111);
    check("midrst_out", 2, out_v[2], 0);
    check("midrst_busy", 2, busy_v[2], 0);
    check("midrst_bounce", 2, bounce_v[2], 0);
    for (int e = 1; e <= 12; e++) begin
      cyc(1'b0, 3'b111);
      check("midrst_rise", 2, out_v[2], (e >= 11));
    end

    // Alternating input every 2 cycles at STABLE_CNT=1: one out toggle per change.
    toggles  = 0;
    prev_out = out_v[1];
    for (int k = 0; k < 25; k++) begin
      cyc(1'b0, (k < 20) ? (((k / 2) % 2 == 0) ? 3'b000 : 3'b111) : 3'b111);
      if (out_v[1] !== prev_out) toggles++;
      prev_out = out_v[1];
    end
    check("alt_toggles", 1, toggles, 10);

    // Randomised bouncing against the reference model.
    v = in_v;
    for (int k = 0; k < 3000; k++) begin
      for (int d = 0; d < 3; d++) begin
        hold[d]--;
        if (hold[d] <= 0) begin
          v[d]    = ~v[d];
          hold[d] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3))
                                                : int'($urandom_range(1, 16));
        end
      end
      cyc(($urandom_range(0, 499) == 0), v);
    end

    for (int d = 0; d < 3; d++) check("bounce_total", d, dut_bounces[d], aborts[d]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
